// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FIFO defaults and the packed status word
// consumed by the status register mux.
package uart_pkg;

    localparam int unsigned UART_TF_DEPTH_LOG2 = 4;
    localparam int unsigned UART_TF_WIDTH      = 8;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic hf;
        logic ff;
        logic ef;
    } uart_status_t;

endpackage

// File: rtl/uart_tf_fifo_if.sv
// Host/transmitter-side bundle of the transmit holding FIFO.
// The slave modport is the FIFO itself; master is the host plus transmit state machine.
interface uart_tf_fifo_if
    import uart_pkg::*;
#(
    parameter int unsigned pDepthLog2 = UART_TF_DEPTH_LOG2,
    parameter int unsigned pWidth     = UART_TF_WIDTH
);
    logic                  WE;
    logic [pWidth-1:0]     DI;
    logic                  RE;
    logic [pWidth-1:0]     DO;
    logic                  EF;
    logic                  FF;
    logic                  HF;
    logic [pDepthLog2:0]   Cnt;
    logic                  OVF;
    logic                  UNF;
    logic [pDepthLog2-1:0] WM;
    logic                  IRQ;

    modport master (
        output WE, DI, RE, WM,
        input  DO, EF, FF, HF, Cnt, OVF, UNF, IRQ
    );

    modport slave (
        input  WE, DI, RE, WM,
        output DO, EF, FF, HF, Cnt, OVF, UNF, IRQ
    );
endinterface

// File: rtl/uart_tf_ram.sv
// Transmit FIFO storage: synchronous write, asynchronous read (distributed RAM).
module uart_tf_ram
    import uart_pkg::*;
#(
    parameter int unsigned pDepthLog2 = UART_TF_DEPTH_LOG2,
    parameter int unsigned pWidth     = UART_TF_WIDTH
) (
    input  logic                  Clk,
    input  logic                  we,
    input  logic [pDepthLog2-1:0] waddr,
    input  logic [pWidth-1:0]     wdata,
    input  logic [pDepthLog2-1:0] raddr,
    output logic [pWidth-1:0]     rdata
);
    localparam int unsigned DEPTH = 1 << pDepthLog2;

    logic [pWidth-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tf_fifo.sv
// Transmit holding FIFO (first-word-fall-through) with level/error status.
// Optional low-watermark interrupt enabled by defining UART_TF_IRQ_EN.
module uart_tf_fifo
    import uart_pkg::*;
#(
    parameter int unsigned pDepthLog2 = UART_TF_DEPTH_LOG2,
    parameter int unsigned pWidth     = UART_TF_WIDTH
) (
    input logic                 Clk,
    input logic                 Rst,
    input logic                 Clr,
    uart_tf_fifo_if.slave       fifo
);
    localparam logic [pDepthLog2:0] CNT_FULL = {1'b1, {pDepthLog2{1'b0}}};
    localparam logic [pDepthLog2:0] CNT_HALF = {2'b01, {(pDepthLog2-1){1'b0}}};

    logic [pDepthLog2-1:0] wptr;
    logic [pDepthLog2-1:0] rptr;
    logic [pDepthLog2:0]   cnt;
    logic [pDepthLog2:0]   cnt_nxt;
    uart_status_t          sts;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  flush;
    logic                  irq;

    assign flush = Rst | Clr;
    assign rd_ok = fifo.RE & ~sts.ef;
    // A read on the same edge frees the slot, so a full FIFO still accepts the write.
    assign wr_ok = fifo.WE & (~sts.ff | rd_ok);

    always_comb begin
        cnt_nxt = cnt;
        if (wr_ok & ~rd_ok)      cnt_nxt = cnt + 1'b1;
        else if (rd_ok & ~wr_ok) cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            sts     <= '0;
            sts.ef  <= 1'b1;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            cnt     <= cnt_nxt;
            sts.ef  <= (cnt_nxt == '0);
            sts.ff  <= (cnt_nxt == CNT_FULL);
            sts.hf  <= (cnt_nxt >= CNT_HALF);
            sts.ovf <= sts.ovf | (fifo.WE & ~wr_ok);
            sts.unf <= sts.unf | (fifo.RE & sts.ef);
        end
    end

    uart_tf_ram #(
        .pDepthLog2 (pDepthLog2),
        .pWidth     (pWidth)
    ) u_ram (
        .Clk   (Clk),
        .we    (wr_ok & ~flush),
        .waddr (wptr),
        .wdata (fifo.DI),
        .raddr (rptr),
        .rdata (fifo.DO)
    );

`ifdef UART_TF_IRQ_EN
    always_ff @(posedge Clk) begin
        if (flush) irq <= 1'b0;
        else       irq <= (cnt_nxt <= {1'b0, fifo.WM});
    end
`else
    logic unused_wm;
    assign unused_wm = ^fifo.WM;
    assign irq       = 1'b0;
`endif

    assign fifo.Cnt = cnt;
    assign fifo.EF  = sts.ef;
    assign fifo.FF  = sts.ff;
    assign fifo.HF  = sts.hf;
    assign fifo.OVF = sts.ovf;
    assign fifo.UNF = sts.unf;
    assign fifo.IRQ = irq;
endmodule

// File: tb/tb_uart_tf_fifo.sv
// Directed self-checking bench for uart_tf_fifo (16 x 8 configuration).
module tb_uart_tf_fifo;
    import uart_pkg::*;

`ifdef UART_TF_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Rst;
    logic Clr;
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_tf_fifo_if #(.pDepthLog2(4), .pWidth(8)) bus ();

    uart_tf_fifo #(.pDepthLog2(4), .pWidth(8)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .Clr  (Clr),
        .fifo (bus.slave)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        bus.WE = 1'b1;
        bus.DI = d;
        step();
        bus.WE = 1'b0;
    endtask

    task automatic rd();
        bus.RE = 1'b1;
        step();
        bus.RE = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ef"},  32'(bus.EF),  32'd1);
        chk({tag, "_cnt"}, 32'(bus.Cnt), 32'd0);
        chk({tag, "_ff"},  32'(bus.FF),  32'd0);
        chk({tag, "_hf"},  32'(bus.HF),  32'd0);
        chk({tag, "_ovf"}, 32'(bus.OVF), 32'd0);
        chk({tag, "_unf"}, 32'(bus.UNF), 32'd0);
        chk({tag, "_irq"}, 32'(bus.IRQ), 32'd0);
    endtask

    initial begin
        Rst = 1'b1; Clr = 1'b0;
        bus.WE = 1'b0; bus.RE = 1'b0; bus.DI = '0; bus.WM = 4'd2;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        chk_idle("reset");
        step();
        Clr = 1'b1; step(); Clr = 1'b0;
        chk_idle("clr_empty");

        // FWFT head stays stable without RE
        wr(8'h41); wr(8'h42); wr(8'h43);
        chk("abc_cnt", 32'(bus.Cnt), 32'd3);
        for (int i = 0; i < 5; i++) begin
            chk("hold_do", 32'(bus.DO), 32'h41);
            step();
        end
        rd(); chk("rd1_do", 32'(bus.DO), 32'h42); chk("rd1_cnt", 32'(bus.Cnt), 32'd2);
        rd(); chk("rd2_do", 32'(bus.DO), 32'h43);
        rd(); chk("rd3_ef", 32'(bus.EF), 32'd1); chk("rd3_cnt", 32'(bus.Cnt), 32'd0);
        chk("rd3_unf", 32'(bus.UNF), 32'd0);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) begin
            wr(8'(i));
            chk("fill_cnt", 32'(bus.Cnt), 32'(i + 1));
            chk("fill_hf",  32'(bus.HF),  32'(i + 1 >= 8));
            chk("fill_ff",  32'(bus.FF),  32'(i == 15));
        end
        wr(8'hFF);
        chk("ovf_set", 32'(bus.OVF), 32'd1);
        chk("ovf_cnt", 32'(bus.Cnt), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_do", 32'(bus.DO), 32'(i));
            rd();
        end
        chk("drain_ef", 32'(bus.EF), 32'd1);
        chk("drain_ff", 32'(bus.FF), 32'd0);

        // Full with simultaneous write and read
        for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
        bus.RE = 1'b1; wr(8'hAA); bus.RE = 1'b0;
        chk("fullrw_cnt", 32'(bus.Cnt), 32'd16);
        chk("fullrw_ff",  32'(bus.FF),  32'd1);
        for (int i = 1; i < 16; i++) begin
            chk("fullrw_do", 32'(bus.DO), 32'(8'h10 + i));
            rd();
        end
        chk("fullrw_last", 32'(bus.DO), 32'hAA);
        rd();
        chk("fullrw_ef", 32'(bus.EF), 32'd1);

        // Empty with simultaneous write and read
        Clr = 1'b1; step(); Clr = 1'b0;
        chk("clr_ovf", 32'(bus.OVF), 32'd0);
        bus.RE = 1'b1; wr(8'h55); bus.RE = 1'b0;
        chk("emptyrw_unf", 32'(bus.UNF), 32'd1);
        chk("emptyrw_cnt", 32'(bus.Cnt), 32'd1);
        chk("emptyrw_do",  32'(bus.DO),  32'h55);
        chk("emptyrw_ef",  32'(bus.EF),  32'd0);
        rd();
        Clr = 1'b1; step(); Clr = 1'b0;
        chk("clr_unf", 32'(bus.UNF), 32'd0);

        // Low-watermark interrupt, WM=2
        for (int i = 0; i < 4; i++) wr(8'(8'h60 + i));
        chk("irq_w4", 32'(bus.IRQ), 32'd0);
        rd();
        chk("irq_r1", 32'(bus.IRQ), 32'd0);
        rd();
        chk("irq_r2", 32'(bus.IRQ), 32'(IRQ_EN));
        wr(8'h70);
        chk("irq_w1", 32'(bus.IRQ), 32'd0);
        chk("irq_cnt", 32'(bus.Cnt), 32'd3);

        // Clr wins over a concurrent write
        Clr = 1'b1; wr(8'h99); Clr = 1'b0;
        chk("clrwr_cnt", 32'(bus.Cnt), 32'd0);
        chk("clrwr_ef",  32'(bus.EF),  32'd1);
        chk("clrwr_irq", 32'(bus.IRQ), 32'd0);
        wr(8'h77);
        chk("postclr_do",  32'(bus.DO),  32'h77);
        chk("postclr_cnt", 32'(bus.Cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
